team_01_wb_master: RTL and testbench
====================================

Name: team_01_wb_master

Overview:
Single-outstanding Wishbone classic master that sits directly upstream of the team_01 top-level bus pins (ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O/DAT_I/ACK_I). It converts a simple valid/ready request from team logic into one Wishbone cycle and returns a one-cycle response. A bounded timeout guarantees forward progress when no slave acknowledges.

Parameters:
TIMEOUT_CYCLES, 255, max cycles CYC_O stays high without ACK_I before abort (1..2^TO_W-1)
TO_W, 8, width of timeout counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  32  byte address
req_wdata  input  32  write data
req_sel  input  4  byte lane enables
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  32  read data (0 for writes and errors)
rsp_err  output  1  timeout abort flag, valid with rsp_valid
ADR_O  output  32  Wishbone address
DAT_O  output  32  Wishbone write data
SEL_O  output  4  Wishbone byte select
WE_O  output  1  Wishbone write enable
STB_O  output  1  Wishbone strobe
CYC_O  output  1  Wishbone cycle
DAT_I  input  32  Wishbone read data
ACK_I  input  1  Wishbone acknowledge

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE; all outputs 0 except req_ready, which is 1 once in IDLE. Timeout counter 0.
- All outputs are registered or decoded from state only; no combinational path from req_* or ACK_I to outputs.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr/wdata/sel/we into ADR_O/DAT_O/SEL_O/WE_O.
  - Set CYC_O=STB_O=1, clear counter, go to BUS.
- BUS:
  - req_ready=0. ADR_O/DAT_O/SEL_O/WE_O held stable.
  - On ACK_I=1: drop CYC_O/STB_O on the same edge. rsp_rdata=DAT_I if read, else 0. rsp_err=0. Go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: drop CYC_O/STB_O, rsp_rdata=0, rsp_err=1, go to RESP.
  - Else counter+1.
- RESP:
  - rsp_valid=1 for exactly one cycle; no backpressure. req_ready=0. Next state IDLE.
  - rsp_rdata/rsp_err hold until the next response is loaded.
- Latency: request accepted at edge 0. CYC_O/STB_O high from cycle 1. ACK_I sampled high at edge k (k>=1) gives rsp_valid in cycle k+1. Minimum is 3 cycles request-to-response; back-to-back throughput is 1 transaction per 3 cycles with zero-wait slaves.
- Simultaneous ACK_I and timeout expiry: ACK wins, rsp_err=0.
- ACK_I outside BUS is ignored and causes no state change.
- ADR_O/DAT_O/SEL_O/WE_O retain their last values in IDLE/RESP; only CYC_O/STB_O qualify the bus.
- req_valid is ignored outside IDLE. No request queuing; the requester must hold the request until req_ready.
- Reset asserted mid-BUS: CYC_O/STB_O drop immediately, no response is issued, the transaction is lost.
- Counter never wraps: the abort always occurs at TIMEOUT_CYCLES cycles of CYC_O high.

Test Plan:
- Read, zero-wait: req addr=0x3000_0004, we=0. Slave ACKs the first cycle CYC_O is high with DAT_I=0xDEAD_BEEF -> CYC_O high exactly 1 cycle; rsp_valid 1 cycle later with rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Write, 3 wait states: addr=0x3000_0010, wdata=0x1234_5678, sel=0xF. ACK after 4 cycles -> ADR_O/DAT_O/SEL_O/WE_O stable all 4 cycles; rsp_valid with rsp_rdata=0, rsp_err=0; req_ready low throughout.
- Timeout: TIMEOUT_CYCLES=4, no ACK -> CYC_O high exactly 4 cycles; rsp_valid with rsp_err=1, rsp_rdata=0; returns to IDLE.
- ACK on expiry cycle: TIMEOUT_CYCLES=4, ACK on 4th cycle with DAT_I=0xA5A5_A5A5 -> rsp_err=0, rsp_rdata=0xA5A5_A5A5.
- Back-to-back: req_valid held high with 3 different reads, zero-wait slave -> accepts spaced exactly 3 cycles apart; 3 responses in order with correct data.
- Reset mid-BUS: assert rst 2 cycles into a wait-state read -> CYC_O/STB_O/rsp_valid 0 in the same cycle; no rsp_valid after release; req_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/team_01_wb_master.sv
// -----------------------------------------------------------------------------
// team_01_wb_master
//
// Single-outstanding Wishbone classic master. Turns one valid/ready request
// into one Wishbone cycle and returns a one-cycle response strobe. If no slave
// acknowledges within TIMEOUT_CYCLES cycles of CYC_O high, the cycle is
// aborted and the response carries rsp_err=1.
//
// Ports
//   clk, rst                  : clock, asynchronous active-high reset
//   req_valid/req_ready       : request handshake (accepted when both high)
//   req_we/addr/wdata/sel     : request attributes
//   rsp_valid/rsp_rdata/err   : one-cycle response, data/err held afterwards
//   ADR_O/DAT_O/SEL_O/WE_O    : Wishbone attributes, held between cycles
//   STB_O/CYC_O               : Wishbone qualifiers, high only in BUS
//   DAT_I/ACK_I               : Wishbone slave response
//
// Every output is a register or a decode of the state register, so there is
// no combinational path from req_* or ACK_I to any output.
// -----------------------------------------------------------------------------
module team_01_wb_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_sel,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Counter value seen in the last BUS cycle before abort; the counter starts
  // at 0 on the first BUS cycle, so it never needs to wrap.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_cnt;
  logic            w_expire;

  assign w_expire = (r_cnt == TO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: the default assignment first keeps this block latch-free even when a
  // branch below does not assign w_next.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid)           w_next = S_BUS;
      S_BUS:   if (ACK_I || w_expire)   w_next = S_RESP;
      S_RESP:                           w_next = S_IDLE;
      default:                          w_next = S_IDLE;
    endcase
  end

  // Bus attributes, timeout counter and response payload. ACK is tested before
  // expiry so an acknowledge on the final allowed cycle still succeeds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ADR_O     <= '0;
      DAT_O     <= '0;
      SEL_O     <= '0;
      WE_O      <= 1'b0;
      r_cnt     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            ADR_O <= req_addr;
            DAT_O <= req_wdata;
            SEL_O <= req_sel;
            WE_O  <= req_we;
            r_cnt <= '0;
          end
        end
        S_BUS: begin
          if (ACK_I) begin
            rsp_rdata <= WE_O ? 32'h0 : DAT_I;
            rsp_err   <= 1'b0;
          end else if (w_expire) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded from state only; reset forces IDLE, so CYC_O/STB_O fall at once.
  assign req_ready = (r_state == S_IDLE);
  assign CYC_O     = (r_state == S_BUS);
  assign STB_O     = (r_state == S_BUS);
  assign rsp_valid = (r_state == S_RESP);

endmodule

// File: tb/tb_team_01_wb_master.sv
// -----------------------------------------------------------------------------
// tb_team_01_wb_master
//
// Directed bench for team_01_wb_master built with TIMEOUT_CYCLES=4. Inputs are
// driven 1 time unit after the rising edge and outputs are sampled there too,
// i.e. they reflect the state loaded by that edge.
// -----------------------------------------------------------------------------
module tb_team_01_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] ADR_O, DAT_O, DAT_I;
  logic [3:0]  SEL_O;
  logic        WE_O, STB_O, CYC_O, ACK_I;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  team_01_wb_master #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ADR_O     (ADR_O),
    .DAT_O     (DAT_O),
    .SEL_O     (SEL_O),
    .WE_O      (WE_O),
    .STB_O     (STB_O),
    .CYC_O     (CYC_O),
    .DAT_I     (DAT_I),
    .ACK_I     (ACK_I)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_sel   = sel;
  endtask

  // {req_ready, CYC_O, STB_O, rsp_valid, rsp_err}
  task automatic test_reset;
    rst = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if ({req_ready, CYC_O, STB_O, rsp_valid, rsp_err} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 10000",
               {req_ready, CYC_O, STB_O, rsp_valid, rsp_err});
    end
    n_vec++;
    if ({ADR_O, DAT_O, SEL_O, WE_O, rsp_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data: adr %h dat %h sel %h we %b rdata %h expected all 0",
               ADR_O, DAT_O, SEL_O, WE_O, rsp_rdata);
    end
    step();
    step();
    rst = 1'b0;
    step();
    n_vec++;
    if ({req_ready, CYC_O, rsp_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_release: got %b expected 100", {req_ready, CYC_O, rsp_valid});
    end
  endtask

  task automatic test_read_zero_wait;
    drive_req(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    step();                                   // accept edge
    req_valid = 1'b0;
    n_vec++;
    if ({req_ready, CYC_O, STB_O, WE_O, rsp_valid} !== 5'b01100 || ADR_O !== 32'h3000_0004) begin
      n_err++;
      $display("FAIL rd0_bus: ctrl %b adr %h expected 01100 adr 30000004",
               {req_ready, CYC_O, STB_O, WE_O, rsp_valid}, ADR_O);
    end
    ACK_I = 1'b1;
    DAT_I = 32'hDEAD_BEEF;
    step();
    ACK_I = 1'b0;
    DAT_I = 32'h0;
    n_vec++;
    if ({CYC_O, STB_O, rsp_valid, rsp_err} !== 4'b0010 || rsp_rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL rd0_rsp: ctrl %b rdata %h expected 0010 rdata deadbeef",
               {CYC_O, STB_O, rsp_valid, rsp_err}, rsp_rdata);
    end
    step();
    n_vec++;
    if ({req_ready, rsp_valid} !== 2'b10 || rsp_rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL rd0_hold: ready/valid %b rdata %h expected 10 rdata deadbeef",
               {req_ready, rsp_valid}, rsp_rdata);
    end
  endtask

  // Write with 3 wait states; a different request is held on req_* during BUS
  // and must not disturb the latched attributes.
  task automatic test_write_wait;
    int bad = 0;
    drive_req(1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF);
    step();
    drive_req(1'b0, 32'h0000_0BAD, 32'h0BAD_0BAD, 4'h1);
    DAT_I = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      if (CYC_O !== 1'b1 || STB_O !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
          ADR_O !== 32'h3000_0010 || DAT_O !== 32'h1234_5678 || SEL_O !== 4'hF || WE_O !== 1'b1)
        bad++;
      ACK_I = (i == 3);
      if (i == 3) req_valid = 1'b0;
      step();
    end
    ACK_I = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL wr_stable: %0d unstable BUS cycles expected 0", bad);
    end
    n_vec++;
    if ({CYC_O, rsp_valid, rsp_err, req_ready} !== 4'b0100 || rsp_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL wr_rsp: ctrl %b rdata %h expected 0100 rdata 00000000",
               {CYC_O, rsp_valid, rsp_err, req_ready}, rsp_rdata);
    end
    step();
  endtask

  // ACK on the 4th (expiry) cycle: acknowledge wins over timeout.
  task automatic test_ack_on_expiry;
    int cyc = 0;
    drive_req(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    step();
    req_valid = 1'b0;
    DAT_I = 32'hA5A5_A5A5;
    for (int i = 0; i < 4; i++) begin
      if (CYC_O === 1'b1) cyc++;
      ACK_I = (i == 3);
      step();
    end
    ACK_I = 1'b0;
    n_vec++;
    if (cyc != 4) begin
      n_err++;
      $display("FAIL ackexp_cyc: CYC_O high %0d cycles expected 4", cyc);
    end
    n_vec++;
    if ({CYC_O, rsp_valid, rsp_err} !== 3'b010 || rsp_rdata !== 32'hA5A5_A5A5) begin
      n_err++;
      $display("FAIL ackexp_rsp: ctrl %b rdata %h expected 010 rdata a5a5a5a5",
               {CYC_O, rsp_valid, rsp_err}, rsp_rdata);
    end
    step();
  endtask

  task automatic test_timeout;
    int cyc = 0;
    bit seen = 0;
    drive_req(1'b0, 32'h3000_0030, 32'h0, 4'h3);
    step();
    req_valid = 1'b0;
    DAT_I = 32'h1111_1111;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (rsp_valid === 1'b1) begin
        seen = 1;
        n_vec++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
          n_err++;
          $display("FAIL to_rsp: err %b rdata %h expected err 1 rdata 00000000",
                   rsp_err, rsp_rdata);
        end
      end else begin
        if (CYC_O === 1'b1) cyc++;
        step();
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL to_wait: no rsp_valid within 12 cycles");
    end
    n_vec++;
    if (cyc != 4) begin
      n_err++;
      $display("FAIL to_cyc: CYC_O high %0d cycles expected 4", cyc);
    end
    step();
    n_vec++;
    if ({req_ready, CYC_O, rsp_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL to_idle: got %b expected 100", {req_ready, CYC_O, rsp_valid});
    end
  endtask

  // req_valid held high over three reads with a zero-wait slave that returns
  // ADR_O ^ 32'hCAFE_0000.
  task automatic test_back_to_back;
    logic [31:0] addrs [3];
    logic [31:0] exp_d [3];
    int acc_t [3];
    int n_acc = 0, n_rsp = 0, t = 0;
    logic rdy;
    addrs[0] = 32'h0000_0100; exp_d[0] = 32'hCAFE_0100;
    addrs[1] = 32'h0000_0204; exp_d[1] = 32'hCAFE_0204;
    addrs[2] = 32'h0000_0308; exp_d[2] = 32'hCAFE_0308;
    drive_req(1'b0, addrs[0], 32'h0, 4'hF);
    while (n_rsp < 3 && t < 30) begin
      rdy = req_ready;
      step();
      t++;
      if (rdy && req_valid) begin
        acc_t[n_acc] = t;
        n_acc++;
        if (n_acc < 3) drive_req(1'b0, addrs[n_acc], 32'h0, 4'hF);
        else req_valid = 1'b0;
      end
      if (rsp_valid === 1'b1) begin
        n_vec++;
        if (rsp_rdata !== exp_d[n_rsp] || rsp_err !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_data%0d: rdata %h err %b expected %h err 0",
                   n_rsp, rsp_rdata, rsp_err, exp_d[n_rsp]);
        end
        n_rsp++;
      end
      ACK_I = CYC_O;
      DAT_I = ADR_O ^ 32'hCAFE_0000;
    end
    ACK_I = 1'b0;
    n_vec++;
    if (n_rsp != 3 || n_acc != 3) begin
      n_err++;
      $display("FAIL b2b_count: %0d accepts %0d responses expected 3 and 3", n_acc, n_rsp);
    end else begin
      n_vec++;
      if (acc_t[1] - acc_t[0] != 3 || acc_t[2] - acc_t[1] != 3) begin
        n_err++;
        $display("FAIL b2b_spacing: gaps %0d %0d expected 3 3",
                 acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
      end
    end
    step();
  endtask

  // Reset two cycles into a wait-state read; afterwards a stray ACK_I in IDLE
  // must not start anything.
  task automatic test_reset_mid_bus;
    int bad = 0;
    drive_req(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({CYC_O, STB_O, rsp_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL rstbus_drop: CYC/STB/rsp_valid %b expected 000", {CYC_O, STB_O, rsp_valid});
    end
    step();
    rst = 1'b0;
    ACK_I = 1'b1;
    DAT_I = 32'h5555_AAAA;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstbus_ready: req_ready %b expected 1", req_ready);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid !== 1'b0 || CYC_O !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    ACK_I = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL rstbus_quiet: %0d cycles with activity expected 0", bad);
    end
  endtask

  initial begin
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_sel   = '0;
    DAT_I     = '0;
    ACK_I     = 1'b0;
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_ack_on_expiry();
    test_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
